// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;

  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, flush > clear/set priority,
// and a registered population count of the pending vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic [NREGS-1:0] pending,
  output logic [AW:0]      pend_cnt
);

  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]      cnt_nxt;

  // Addresses past the last architectural register are ignored.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREGS));
  endfunction

  // Next pending vector: flush clears everything, otherwise clear then set,
  // so an issue to the register being written back keeps it pending.
  always_comb begin
    pend_nxt = pending;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      if (wb_en && wb_addr != '0 && in_range(wb_addr))
        pend_nxt[wb_addr] = 1'b0;
      if (iss_valid && iss_rd != '0 && in_range(iss_rd))
        pend_nxt[iss_rd] = 1'b1;
    end
  end

  // Population count of the next vector so the count lands on the same edge.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[i]};
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-through bypass read ports, a pending-write
// scoreboard and a registered debug copy of one register.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN    = XLEN_DEF,
  parameter  int NREGS   = NREGS_DEF,
  parameter  int NRD     = 2,
  parameter  int DBG_REG = REG_A0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic [AW:0]       pend_cnt,
  output logic [XLEN-1:0]   dbg
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic             wr_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREGS));
  endfunction

  assign wr_ok = wb_en && (wb_addr != '0) && in_range(wb_addr);

  // Register storage; x0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Debug copy trails the storage by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dbg <= '0;
    else
      dbg <= regs[DBG_REG];
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .pending   (pending),
    .pend_cnt  (pend_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[i*AW +: AW];

    // Read mux: zero for x0/out-of-range, bypass a same-cycle write-back,
    // and a pending bit is hidden while its producer writes back.
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (addr != '0 && in_range(addr)) begin
        if (wb_en && wb_addr == addr)
          data = wb_data;
        else
          data = regs[addr];
        busy = pending[addr] && !(wb_en && wb_addr == addr);
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i]              = busy;
  end

endmodule
